// File: rtl/oram_writer.sv
// Buffers translated ARM words in a small FIFO and writes them sequentially into the output RAM.
// Latency: an accepted word reaches mem_we one edge after acceptance when idle; one word per cycle with constant ack.
// Backpressure: ready drops when the FIFO is full, overflow is set or a drain is running; mem_we holds until mem_ack.
module oram_writer #(
    parameter int          ADDRESS_WIDTH = 16,
    parameter int          FIFO_DEPTH    = 4,
    parameter int unsigned ORAM_LIMIT    = 16'h1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              data,
    input  logic                     start,
    output logic                     ready,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic                     flush,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [31:0]              mem_wdata,
    output logic                     mem_we,
    input  logic                     mem_ack,
    output logic [ADDRESS_WIDTH-1:0] word_count,
    output logic                     overflow,
    output logic                     done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   PTR_ONE = 1;
    localparam logic [PW-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {IDLE, WRITE, DRAIN, HALT} state_t;

    state_t state;

    // FIFO storage and pointers; the extra pointer bit separates full from empty
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [PW:0]   occ;
    logic [PW-1:0] rd_idx;
    logic [PW-1:0] rd_idx_nxt;
    logic          full;
    logic          empty;

    logic          push;
    logic          pop;
    logic          more_after_pop;
    logic [31:0]   head_now;
    logic [31:0]   head_next;
    logic [32:0]   next_addr_ext;
    logic          limit_hit;
    logic          flush_pend;

    assign occ        = wr_ptr - rd_ptr;
    assign rd_idx     = rd_ptr[PW-1:0];
    assign rd_idx_nxt = rd_idx + IDX_ONE;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign ready = !full && !overflow && (state != DRAIN);
    assign push  = start && ready;
    // mem_we is only ever high in WRITE or DRAIN, so an ack on a live write is a pop
    assign pop   = mem_we && mem_ack;

    // Word that becomes the head once the current head is popped; a same-cycle push
    // supplies it when the FIFO holds only the word being written.
    assign head_now       = fifo_mem[rd_idx];
    assign head_next      = (occ > PTR_ONE) ? fifo_mem[rd_idx_nxt] : data;
    assign more_after_pop = (occ > PTR_ONE) || push;

    // A write whose successor address would reach the limit is the last one allowed
    assign next_addr_ext = 33'(mem_addr) + 33'd4;
    assign limit_hit     = (next_addr_ext >= 33'(ORAM_LIMIT));

    // FIFO storage write; contents need no reset because pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PW-1:0]] <= data;
        end
    end

    // FIFO pointers; HALT discards whatever is still queued
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (state == HALT) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Write sequencer: IDLE/WRITE/DRAIN/HALT with all RAM-side outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            mem_addr   <= base_addr;
            word_count <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if ((!empty || push) && !overflow) begin
                        // Bypass the FIFO read when empty so the first word issues immediately
                        mem_we     <= 1'b1;
                        mem_wdata  <= empty ? data : head_now;
                        state      <= flush ? DRAIN : WRITE;
                        flush_pend <= 1'b0;
                    end else if (flush) begin
                        done <= 1'b1;
                    end
                end
                WRITE, DRAIN: begin
                    if (flush && (state == WRITE)) begin
                        flush_pend <= 1'b1;
                    end
                    if (pop) begin
                        mem_addr   <= mem_addr + ADDRESS_WIDTH'(4);
                        word_count <= word_count + ADDRESS_WIDTH'(1);
                        flush_pend <= 1'b0;
                        if (limit_hit) begin
                            overflow <= 1'b1;
                            mem_we   <= 1'b0;
                            state    <= HALT;
                        end else if (more_after_pop) begin
                            mem_wdata <= head_next;
                            if ((state == DRAIN) || flush_pend || flush) begin
                                state <= DRAIN;
                            end
                        end else begin
                            mem_we <= 1'b0;
                            if ((state == DRAIN) || flush_pend || flush) begin
                                done <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                end
                HALT: begin
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oram_writer.sv
// Directed bench for oram_writer: two instances share stimulus, one with a tiny RAM limit.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Every expected value below is hand-derived from the block's intended behaviour.
module tb_oram_writer;

    logic        clk;
    logic        reset;
    logic [31:0] data;
    logic        start;
    logic [15:0] base_addr;
    logic        flush;
    logic        mem_ack;

    logic        ready,     l_ready;
    logic [15:0] mem_addr,  l_mem_addr;
    logic [31:0] mem_wdata, l_mem_wdata;
    logic        mem_we,    l_mem_we;
    logic [15:0] word_count, l_word_count;
    logic        overflow,  l_overflow;
    logic        done,      l_done;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] w [8];

    oram_writer dut (
        .clk(clk), .reset(reset), .data(data), .start(start), .ready(ready),
        .base_addr(base_addr), .flush(flush), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ack(mem_ack),
        .word_count(word_count), .overflow(overflow), .done(done)
    );

    oram_writer #(.ORAM_LIMIT(8)) dut_lim (
        .clk(clk), .reset(reset), .data(data), .start(start), .ready(l_ready),
        .base_addr(base_addr), .flush(flush), .mem_addr(l_mem_addr),
        .mem_wdata(l_mem_wdata), .mem_we(l_mem_we), .mem_ack(mem_ack),
        .word_count(l_word_count), .overflow(l_overflow), .done(l_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [15:0] b);
        base_addr = b;
        reset     = 1'b1;
        start     = 1'b0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; mem_ack = 1'b0;
        data = '0; base_addr = 16'h0100;
        for (int i = 0; i < 8; i++) w[i] = 32'hA000_0000 + 32'(i * 16 + 3);

        // Reset state
        tick(); tick();
        chk("rst_mem_we", mem_we, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_mem_addr", mem_addr, 16'h0100);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_ready", ready, 1);

        // Two words back to back with ack tied high
        do_reset(16'h0000);
        mem_ack = 1'b1;
        tick();
        start = 1'b1; data = 32'hE340_0001;
        tick();
        chk("b2b_we0", mem_we, 1);
        chk("b2b_addr0", mem_addr, 0);
        chk("b2b_wdata0", mem_wdata, 32'hE340_0001);
        data = 32'hE52D_0004;
        tick();
        chk("b2b_we1", mem_we, 1);
        chk("b2b_addr1", mem_addr, 4);
        chk("b2b_wdata1", mem_wdata, 32'hE52D_0004);
        chk("b2b_cnt1", word_count, 1);
        start = 1'b0;
        tick();
        chk("b2b_cnt2", word_count, 2);
        chk("b2b_we_end", mem_we, 0);
        chk("b2b_addr_end", mem_addr, 8);

        // FIFO fill with ack held low: fifth word refused, write stays stable
        do_reset(16'h0000);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("full_ready%0d", i), ready, (i < 4) ? 1 : 0);
            start = 1'b1; data = w[i];
            tick();
        end
        start = 1'b0;
        tick();
        chk("full_we", mem_we, 1);
        chk("full_addr", mem_addr, 0);
        chk("full_wdata", mem_wdata, w[0]);
        chk("full_ready_hold", ready, 0);
        mem_ack = 1'b1;
        for (int j = 1; j < 4; j++) begin
            tick();
            chk($sformatf("full_drain_wdata%0d", j), mem_wdata, w[j]);
            chk($sformatf("full_drain_addr%0d", j), mem_addr, 16'(4 * j));
            chk($sformatf("full_drain_cnt%0d", j), word_count, j);
        end
        tick();
        chk("full_end_we", mem_we, 0);
        chk("full_end_cnt", word_count, 4);
        chk("full_end_addr", mem_addr, 16);

        // Limit of 8 bytes: third word never written, writer halts
        do_reset(16'h0000);
        mem_ack = 1'b1; start = 1'b1; data = w[5];
        tick();
        data = w[6];
        tick();
        data = w[7];
        tick();
        start = 1'b0;
        tick();
        chk("lim_overflow", l_overflow, 1);
        chk("lim_cnt", l_word_count, 2);
        chk("lim_we", l_mem_we, 0);
        chk("lim_ready", l_ready, 0);
        chk("lim_addr", l_mem_addr, 8);
        chk("nolim_cnt", word_count, 3);
        chk("nolim_overflow", overflow, 0);
        flush = 1'b1;
        tick();
        chk("lim_flush_done", l_done, 0);
        flush = 1'b0; start = 1'b1; data = 32'h1234_5678;
        tick(); tick();
        chk("lim_halt_we", l_mem_we, 0);
        chk("lim_halt_cnt", l_word_count, 2);
        chk("lim_halt_overflow", l_overflow, 1);

        // Flush with three queued words, then release ack
        do_reset(16'h0000);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data = w[i];
            tick();
        end
        start = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_done_early", done, 0);
        chk("fl_wdata0", mem_wdata, w[0]);
        mem_ack = 1'b1;
        tick();
        chk("fl_wdata1", mem_wdata, w[1]);
        chk("fl_ready_drain", ready, 0);
        chk("fl_done_mid1", done, 0);
        tick();
        chk("fl_wdata2", mem_wdata, w[2]);
        chk("fl_addr2", mem_addr, 8);
        chk("fl_done_mid2", done, 0);
        tick();
        chk("fl_done", done, 1);
        chk("fl_cnt", word_count, 3);
        chk("fl_we_end", mem_we, 0);
        tick();
        chk("fl_done_once", done, 0);
        chk("fl_ready_idle", ready, 1);

        // Flush on an empty idle writer
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_empty_done", done, 1);
        tick();
        chk("fl_empty_done_off", done, 0);

        // Reset in the middle of a stalled write, colliding with start/flush/ack
        do_reset(16'h0040);
        mem_ack = 1'b1; start = 1'b1; data = w[3];
        tick();
        chk("mid_addr0", mem_addr, 16'h0040);
        start = 1'b0;
        tick();
        chk("mid_cnt1", word_count, 1);
        mem_ack = 1'b0; start = 1'b1; data = w[4];
        tick();
        start = 1'b0;
        tick();
        chk("mid_we_stall", mem_we, 1);
        chk("mid_addr_stall", mem_addr, 16'h0044);
        reset = 1'b1; mem_ack = 1'b1; start = 1'b1; flush = 1'b1;
        tick();
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_cnt", word_count, 0);
        chk("mid_rst_addr", mem_addr, 16'h0040);
        chk("mid_rst_done", done, 0);
        reset = 1'b0; mem_ack = 1'b0; start = 1'b0; flush = 1'b0;
        tick();
        chk("mid_rst_nopush", mem_we, 0);

        // Steady state: two words queued, push and pop every cycle
        do_reset(16'h0000);
        start = 1'b1; data = w[0];
        tick();
        data = w[1];
        tick();
        mem_ack = 1'b1;
        for (int k = 2; k < 8; k++) begin
            data = w[k];
            tick();
            chk($sformatf("ss_wdata%0d", k), mem_wdata, w[k - 1]);
            chk($sformatf("ss_cnt%0d", k), word_count, k - 1);
            chk($sformatf("ss_ready%0d", k), ready, 1);
        end
        start = 1'b0;
        tick();
        chk("ss_tail_wdata", mem_wdata, w[7]);
        tick();
        chk("ss_end_cnt", word_count, 8);
        chk("ss_end_addr", mem_addr, 32);
        chk("ss_end_we", mem_we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
